// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out MSB-first, one bit per clock. The
// final bit of each frame is flagged on ser_last, and completed frames are
// counted modulo 256.
//
// Optional feature macro: BIT_SERIALIZER_PARITY_EN
//   When defined, an even-parity bit (XOR of all data bits) is appended after
//   in_data[0]. ser_last then marks the parity bit.
//
// Parameters:
//   WIDTH     data bits per frame (2..32)
//   IDLE_BIT  level on ser_out when no frame is active
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   source presents a word on in_data
//   in_ready   out  word can be accepted this cycle (combinational)
//   in_data    in   word to transmit, captured on accept
//   ser_out    out  serial data (registered)
//   ser_valid  out  ser_out carries a frame bit (registered)
//   ser_last   out  ser_out is the final bit of the frame (registered)
//   frame_cnt  out  completed-frame count, wraps at 256 (registered)
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int   WIDTH    = 10,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic [7:0]       frame_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifndef BIT_SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] PEN_IDX  = CW'(WIDTH - 2);
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    // Even parity over a full data word.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [1:0]       state_r,     state_s;
    logic [CW-1:0]    cnt_r,       cnt_s;
    logic [WIDTH-1:0] shreg_r,     shreg_s;
    logic             ser_out_r,   ser_out_s;
    logic             ser_valid_r, ser_valid_s;
    logic             ser_last_r,  ser_last_s;
    logic [7:0]       frame_cnt_r, frame_cnt_s;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_r,    parity_s;
`endif
    logic             in_ready_s;
    logic             accept_s;

    // Ready in IDLE and during the final-bit cycle so frames can abut.
    assign in_ready_s = (state_r == ST_IDLE) || ser_last_r;
    assign accept_s   = in_valid && in_ready_s;

    // Next-state and next-output computation.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shreg_s     = shreg_r;
        ser_out_s   = ser_out_r;
        ser_valid_s = ser_valid_r;
        ser_last_s  = ser_last_r;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_s    = parity_r;
`endif
        if (accept_s) begin
            // MSB goes straight to the output register; the remaining bits
            // are left-aligned in the shift register.
            state_s     = ST_SHIFT;
            cnt_s       = {CW{1'b0}};
            shreg_s     = {in_data[WIDTH-2:0], 1'b0};
            ser_out_s   = in_data[WIDTH-1];
            ser_valid_s = 1'b1;
            ser_last_s  = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_s    = even_parity(in_data);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ser_out_s   = IDLE_BIT;
                    ser_valid_s = 1'b0;
                    ser_last_s  = 1'b0;
                end
                ST_SHIFT: begin
                    if (cnt_r == LAST_IDX) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state_s     = ST_PAR;
                        ser_out_s   = parity_r;
                        ser_last_s  = 1'b1;
`else
                        state_s     = ST_IDLE;
                        ser_out_s   = IDLE_BIT;
                        ser_valid_s = 1'b0;
                        ser_last_s  = 1'b0;
`endif
                    end else begin
                        cnt_s      = cnt_r + CW'(1);
                        ser_out_s  = shreg_r[WIDTH-1];
                        shreg_s    = {shreg_r[WIDTH-2:0], 1'b0};
`ifdef BIT_SERIALIZER_PARITY_EN
                        ser_last_s = 1'b0;
`else
                        ser_last_s = (cnt_r == PEN_IDX);
`endif
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                ST_PAR: begin
                    state_s     = ST_IDLE;
                    ser_out_s   = IDLE_BIT;
                    ser_valid_s = 1'b0;
                    ser_last_s  = 1'b0;
                end
`endif
                default: begin
                    state_s     = ST_IDLE;
                    cnt_s       = {CW{1'b0}};
                    ser_out_s   = IDLE_BIT;
                    ser_valid_s = 1'b0;
                    ser_last_s  = 1'b0;
                end
            endcase
        end

        // A frame completes at the edge that ends its ser_last cycle.
        if (ser_last_r) begin
            frame_cnt_s = frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_s = frame_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            shreg_r     <= {WIDTH{1'b0}};
            ser_out_r   <= IDLE_BIT;
            ser_valid_r <= 1'b0;
            ser_last_r  <= 1'b0;
            frame_cnt_r <= 8'd0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            shreg_r     <= shreg_s;
            ser_out_r   <= ser_out_s;
            ser_valid_r <= ser_valid_s;
            ser_last_r  <= ser_last_s;
            frame_cnt_r <= frame_cnt_s;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_r    <= parity_s;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign ser_out   = ser_out_r;
    assign ser_valid = ser_valid_r;
    assign ser_last  = ser_last_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Directed self-checking bench for bit_serializer (WIDTH=10, IDLE_BIT=1).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic [7:0] frame_cnt;

    int n_checks;
    int n_fail;
    int exp_frames;

    bit_serializer #(.WIDTH(10), .IDLE_BIT(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame bit i of word w: MSB first, parity bit after in_data[0].
    function automatic logic exp_bit(input logic [9:0] w, input int i);
        if (i < 10) return w[9-i];
        else        return ^w;
    endfunction

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 10'h000;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({ser_out, ser_valid, ser_last, in_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_outputs: got out/valid/last/ready=%b, want 1001",
                     {ser_out, ser_valid, ser_last, in_ready});
        end
        n_checks++;
        if (frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_frame_cnt: got %0d, want 0", frame_cnt);
        end
        reset_n    = 1'b1;
        exp_frames = 0;
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 10'b01_0011_0111;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready_idle: got %b, want 1", in_ready);
        end
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            n_checks++;
            if ({ser_out, ser_valid, ser_last} !== {exp_bit(10'h137, i), 1'b1, (i == FL-1)}) begin
                n_fail++;
                $display("FAIL single_bit%0d: got out/valid/last=%b, want %b", i,
                         {ser_out, ser_valid, ser_last}, {exp_bit(10'h137, i), 1'b1, (i == FL-1)});
            end
            if (i == 3) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_ready_busy: got %b, want 0", in_ready);
                end
            end
        end
        exp_frames++;
        @(negedge clk);
        n_checks++;
        if ({ser_out, ser_valid, ser_last, in_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL single_after: got out/valid/last/ready=%b, want 1001",
                     {ser_out, ser_valid, ser_last, in_ready});
        end
        n_checks++;
        if (frame_cnt !== 8'(exp_frames)) begin
            n_fail++;
            $display("FAIL single_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        logic eb;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 10'h137;
        for (int i = 0; i < 2*FL; i++) begin
            @(negedge clk);
            if (i == 0)  in_data  = 10'h3FF;
            if (i == FL) in_valid = 1'b0;
            eb = (i < FL) ? exp_bit(10'h137, i) : exp_bit(10'h3FF, i - FL);
            n_checks++;
            if ({ser_out, ser_valid, ser_last} !== {eb, 1'b1, (i == FL-1 || i == 2*FL-1)}) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got out/valid/last=%b, want %b", i,
                         {ser_out, ser_valid, ser_last}, {eb, 1'b1, (i == FL-1 || i == 2*FL-1)});
            end
        end
        exp_frames += 2;
        @(negedge clk);
        n_checks++;
        if ({ser_out, ser_valid} !== 2'b10 || frame_cnt !== 8'(exp_frames)) begin
            n_fail++;
            $display("FAIL b2b_after: got out/valid=%b cnt=%0d, want 10 cnt=%0d",
                     {ser_out, ser_valid}, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_busy();
        logic eb;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 10'h137;
        for (int i = 0; i < 2*FL; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            if (i == 2) begin
                in_valid = 1'b1;
                in_data  = 10'h2AA;
            end
            if (i == FL) in_valid = 1'b0;
            if (i >= 2 && i < FL) begin
                n_checks++;
                if (in_ready !== (i == FL-1)) begin
                    n_fail++;
                    $display("FAIL busy_ready%0d: got %b, want %b", i, in_ready, (i == FL-1));
                end
            end
            eb = (i < FL) ? exp_bit(10'h137, i) : exp_bit(10'h2AA, i - FL);
            n_checks++;
            if ({ser_out, ser_valid} !== {eb, 1'b1}) begin
                n_fail++;
                $display("FAIL busy_bit%0d: got out/valid=%b, want %b", i,
                         {ser_out, ser_valid}, {eb, 1'b1});
            end
        end
        exp_frames += 2;
        @(negedge clk);
        n_checks++;
        if (ser_valid !== 1'b0 || frame_cnt !== 8'(exp_frames)) begin
            n_fail++;
            $display("FAIL busy_after: got valid=%b cnt=%0d, want 0 cnt=%0d",
                     ser_valid, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 10'h137;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ser_out, ser_valid, ser_last, in_ready} !== 4'b1001 || frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got out/valid/last/ready=%b cnt=%0d, want 1001 cnt=0",
                     {ser_out, ser_valid, ser_last, in_ready}, frame_cnt);
        end
        exp_frames = 0;
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 10'h2AA;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            n_checks++;
            if ({ser_out, ser_valid, ser_last} !== {exp_bit(10'h2AA, i), 1'b1, (i == FL-1)}) begin
                n_fail++;
                $display("FAIL midreset_bit%0d: got out/valid/last=%b, want %b", i,
                         {ser_out, ser_valid, ser_last}, {exp_bit(10'h2AA, i), 1'b1, (i == FL-1)});
            end
        end
        exp_frames++;
        @(negedge clk);
        n_checks++;
        if (frame_cnt !== 8'(exp_frames)) begin
            n_fail++;
            $display("FAIL midreset_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 10'h001;
        for (int f = 1; f <= 256; f++) begin
            for (int b = 0; b < FL; b++) begin
                @(negedge clk);
                if (f == 256 && b == FL-1) in_valid = 1'b0;
                if (f == 256 && b == 0) begin
                    n_checks++;
                    if (frame_cnt !== 8'd255) begin
                        n_fail++;
                        $display("FAIL wrap_255: got %0d, want 255", frame_cnt);
                    end
                end
                if (b == FL-1 && (f == 1 || f == 256)) begin
                    n_checks++;
                    if ({ser_out, ser_last} !== {exp_bit(10'h001, FL-1), 1'b1}) begin
                        n_fail++;
                        $display("FAIL wrap_last_f%0d: got out/last=%b, want %b", f,
                                 {ser_out, ser_last}, {exp_bit(10'h001, FL-1), 1'b1});
                    end
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (frame_cnt !== 8'd0 || ser_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_0: got cnt=%0d valid=%b, want cnt=0 valid=0", frame_cnt, ser_valid);
        end
    endtask

`ifdef BIT_SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [9:0] words [2];
        logic       pbit  [2];
        words[0] = 10'h137; pbit[0] = 1'b0;
        words[1] = 10'h001; pbit[1] = 1'b1;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = words[w];
            for (int i = 0; i < 11; i++) begin
                @(negedge clk);
                if (i == 0) in_valid = 1'b0;
                if (i == 10) begin
                    n_checks++;
                    if ({ser_out, ser_valid, ser_last} !== {pbit[w], 1'b1, 1'b1}) begin
                        n_fail++;
                        $display("FAIL parity_w%0d: got out/valid/last=%b, want %b", w,
                                 {ser_out, ser_valid, ser_last}, {pbit[w], 1'b1, 1'b1});
                    end
                end
            end
            @(negedge clk);
            n_checks++;
            if (ser_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_len_w%0d: got valid=%b, want 0", w, ser_valid);
            end
        end
    endtask
`endif

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_frames = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_reset_mid_frame();
        test_counter_wrap();
`ifdef BIT_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
